// File: rtl/ddr_pkg.sv
// Shared DDR types: command encoding, per-bank state and the mapper's address layout.
package ddr_pkg;

    localparam int NUM_BANKS  = 16;
    localparam int BG_W       = 2;
    localparam int BA_W       = 2;
    localparam int ADDR_ROW_W = 16;
    localparam int COL_W      = 10;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        PRE = 3'd2,
        RD  = 3'd3,
        WR  = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        CLOSED      = 2'd0,
        ACTIVATING  = 2'd1,
        OPEN        = 2'd2,
        PRECHARGING = 2'd3
    } bank_state_e;

    typedef struct packed {
        logic [BG_W-1:0]       bank_group;
        logic [BA_W-1:0]       bank;
        logic [ADDR_ROW_W-1:0] row;
        logic [COL_W-1:0]      column;
    } address_type;

    // Flat bank index as used on the command bus: {bank_group, bank}.
    function automatic logic [BG_W+BA_W-1:0] bank_index(input address_type a);
        return {a.bank_group, a.bank};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr (wrapping).
module rr_arbiter #(
    parameter  int N  = 16,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester's grant is the one left standing.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_scheduler.sv
// Open-page DRAM command scheduler: per-bank row tracking with tRCD/tRP timers,
// class-priority round-robin arbitration and a single registered command output.
module bank_scheduler
    import ddr_pkg::*;
#(
    parameter  int NUM_BANKS = ddr_pkg::NUM_BANKS,
    parameter  int ROW_W     = 16,
    parameter  int IDX_W     = 7,
    parameter  int T_RCD     = 4,
    parameter  int T_RP      = 4,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_BANKS-1:0]              req_valid,
    input  logic [NUM_BANKS-1:0]              req_is_write,
    input  logic [NUM_BANKS-1:0][ROW_W-1:0]   req_row,
    input  logic [NUM_BANKS-1:0][IDX_W-1:0]   req_idx,
    output logic [NUM_BANKS-1:0]              req_ready,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output cmd_e                              cmd_type,
    output logic [BANK_W-1:0]                 cmd_bank,
    output logic [ROW_W-1:0]                  cmd_row,
    output logic [IDX_W-1:0]                  cmd_idx
);

    localparam int TMR_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(T_RP - 1);

    bank_state_e          state_q    [NUM_BANKS];
    logic [TMR_W-1:0]     tmr_q      [NUM_BANKS];
    logic [ROW_W-1:0]     open_row_q [NUM_BANKS];
    logic [BANK_W-1:0]    rr_ptr;

    logic [NUM_BANKS-1:0] col_req, act_req, pre_req;
    logic [NUM_BANKS-1:0] col_gnt, act_gnt, pre_gnt;
    logic [NUM_BANKS-1:0] gnt;
    logic                 arb_free, is_col;
    logic [BANK_W-1:0]    gnt_bank;
    cmd_e                 gnt_type;

    logic                 vld_p1;
    cmd_e                 type_p1;
    logic [BANK_W-1:0]    bank_p1;
    logic [ROW_W-1:0]     row_p1;
    logic [IDX_W-1:0]     idx_p1;

    // Stage p0: candidate classification per bank
    always_comb begin
        col_req = '0;
        act_req = '0;
        pre_req = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (req_valid[b]) begin
                case (state_q[b])
                    CLOSED:  act_req[b] = 1'b1;
                    OPEN: begin
                        if (req_row[b] == open_row_q[b]) col_req[b] = 1'b1;
                        else                             pre_req[b] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    rr_arbiter #(.N(NUM_BANKS)) u_arb_col (.req(col_req), .ptr(rr_ptr), .gnt(col_gnt));
    rr_arbiter #(.N(NUM_BANKS)) u_arb_act (.req(act_req), .ptr(rr_ptr), .gnt(act_gnt));
    rr_arbiter #(.N(NUM_BANKS)) u_arb_pre (.req(pre_req), .ptr(rr_ptr), .gnt(pre_gnt));

    // Highest non-empty class wins; nothing is granted while the output register is stalled.
    always_comb begin
        arb_free = !vld_p1 || cmd_ready;
        gnt      = '0;
        is_col   = 1'b0;
        gnt_bank = '0;
        gnt_type = NOP;
        if (arb_free) begin
            if (|col_gnt) begin
                gnt    = col_gnt;
                is_col = 1'b1;
            end else if (|act_gnt) begin
                gnt = act_gnt;
            end else begin
                gnt = pre_gnt;
            end
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt[b]) gnt_bank = BANK_W'(b);
        end
        if (|gnt) begin
            if (is_col)        gnt_type = req_is_write[gnt_bank] ? WR : RD;
            else if (|act_gnt) gnt_type = ACT;
            else               gnt_type = PRE;
        end
        req_ready = is_col ? gnt : '0;
    end

    // Bank timing advances from the grant, independent of PHY acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b]    <= CLOSED;
                tmr_q[b]      <= '0;
                open_row_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                case (state_q[b])
                    CLOSED: begin
                        if (gnt[b]) begin
                            open_row_q[b] <= req_row[b];
                            if (T_RCD == 1) begin
                                state_q[b] <= OPEN;
                            end else begin
                                state_q[b] <= ACTIVATING;
                                tmr_q[b]   <= RCD_LD;
                            end
                        end
                    end
                    ACTIVATING: begin
                        if (tmr_q[b] <= TMR_W'(1)) begin
                            tmr_q[b]   <= '0;
                            state_q[b] <= OPEN;
                        end else begin
                            tmr_q[b] <= tmr_q[b] - 1'b1;
                        end
                    end
                    OPEN: begin
                        if (gnt[b] && gnt_type == PRE) begin
                            if (T_RP == 1) begin
                                state_q[b] <= CLOSED;
                            end else begin
                                state_q[b] <= PRECHARGING;
                                tmr_q[b]   <= RP_LD;
                            end
                        end
                    end
                    PRECHARGING: begin
                        if (tmr_q[b] <= TMR_W'(1)) begin
                            tmr_q[b]   <= '0;
                            state_q[b] <= CLOSED;
                        end else begin
                            tmr_q[b] <= tmr_q[b] - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Stage p1: command output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr  <= '0;
            vld_p1  <= 1'b0;
            type_p1 <= NOP;
            bank_p1 <= '0;
            row_p1  <= '0;
            idx_p1  <= '0;
        end else if (arb_free) begin
            if (|gnt) begin
                rr_ptr  <= (gnt_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : gnt_bank + 1'b1;
                vld_p1  <= 1'b1;
                type_p1 <= gnt_type;
                bank_p1 <= gnt_bank;
                row_p1  <= req_row[gnt_bank];
                idx_p1  <= req_idx[gnt_bank];
            end else begin
                vld_p1  <= 1'b0;
                type_p1 <= NOP;
                bank_p1 <= '0;
                row_p1  <= '0;
                idx_p1  <= '0;
            end
        end
    end

    assign cmd_valid = vld_p1;
    assign cmd_type  = type_p1;
    assign cmd_bank  = bank_p1;
    assign cmd_row   = row_p1;
    assign cmd_idx   = idx_p1;

endmodule
